// File: rtl/display_pkg.sv
// display_pkg: constants and state type shared by the display arbiter and its
// character buffer.
package display_pkg;

  localparam int DATA_W = 8;

  localparam logic [DATA_W-1:0] CHAR_LF = 8'h0A;
  localparam logic [DATA_W-1:0] CHAR_CR = 8'h0D;

  // IDLE emits the head byte (or the CR of a CR/LF pair); SEND_LF emits the LF
  // that completes the pair and retires the buffered 0x0A.
  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_SEND_LF = 1'b1
  } arb_state_t;

endpackage

// File: rtl/display_arbiter_char_fifo.sv
// char_fifo: first-word-fall-through character buffer. The head entry is
// visible on rdata as soon as it has been written. A push and a pop in the same
// cycle leave the occupancy unchanged, and a push into a full buffer is legal
// when the head is popped in that same cycle (the freed slot is reused).
// Storage is not reset; only pointers and occupancy are.
module char_fifo
  import display_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Write the incoming character into the slot under the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Advance pointers (wrapping naturally at the power-of-two depth) and track occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// display_arbiter: merges CPU and debug-monitor character streams into one
// shared buffer feeding a display sink. The CPU has absolute priority and no
// backpressure; a CPU byte that cannot be stored is dropped and latches the
// sticky overflow flag. The debug port is held off whenever the CPU writes or
// the buffer is full.
// Optional feature: define DISPLAY_ARB_CRLF_EN to expand every 0x0A leaving
// the buffer into the pair 0x0D, 0x0A. Without it, bytes pass unchanged.
module display_arbiter
  import display_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    main_bus,
  input  logic                          load_val,
  input  logic [7:0]                    dbg_data,
  input  logic                          dbg_valid,
  output logic                          dbg_ready,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  logic              full;
  logic              empty;
  logic [7:0]        head;
  logic              pop;
  logic              push;
  logic              cpu_push;
  logic              dbg_push;
  logic [7:0]        wdata;

  // Arbitrate the single write port: CPU first, debug only when the CPU is silent.
  always_comb begin
    dbg_ready = !full && !load_val;
    cpu_push  = load_val && (!full || pop);
    dbg_push  = dbg_valid && dbg_ready;
    push      = cpu_push || dbg_push;
    wdata     = load_val ? main_bus : dbg_data;
  end

  assign out_valid = !empty;

  // Latch a dropped CPU byte until the next reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (load_val && !cpu_push) begin
      overflow <= 1'b1;
    end
  end

`ifdef DISPLAY_ARB_CRLF_EN
  arb_state_t state;

  // Step through the CR/LF expansion of a buffered 0x0A; each half needs out_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ARB_IDLE;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (!empty && (head == CHAR_LF) && out_ready) begin
            state <= ARB_SEND_LF;
          end
        end
        ARB_SEND_LF: begin
          if (out_ready) begin
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Select the emitted character; the 0x0A is only retired once its LF half is taken.
  always_comb begin
    out_data = head;
    pop      = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (head == CHAR_LF) begin
          out_data = CHAR_CR;
        end
        pop = out_valid && out_ready && (head != CHAR_LF);
      end
      ARB_SEND_LF: begin
        out_data = CHAR_LF;
        pop      = out_valid && out_ready;
      end
      default: begin
        out_data = head;
        pop      = 1'b0;
      end
    endcase
  end
`else
  assign out_data = head;
  assign pop      = out_valid && out_ready;
`endif

  char_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter. The reference model is a queue of output symbols:
// each accepted byte appends the symbols the sink must eventually see (a lone
// byte, or CR then LF when CR/LF expansion is built in), the last symbol of a
// byte marking the point where that byte leaves the buffer.
module tb_display_arbiter;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] main_bus = 8'h00;
  logic       load_val = 1'b0;
  logic [7:0] dbg_data = 8'h00;
  logic       dbg_valid = 1'b0;
  logic       dbg_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       overflow;
  logic [3:0] fifo_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
  } sym_t;

  sym_t mq[$];
  logic m_ovf = 1'b0;

  display_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .main_bus   (main_bus),
    .load_val   (load_val),
    .dbg_data   (dbg_data),
    .dbg_valid  (dbg_valid),
    .dbg_ready  (dbg_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

  function automatic int m_bytes();
    int n = 0;
    foreach (mq[i]) if (mq[i].last) n++;
    return n;
  endfunction

  task automatic m_push(input logic [7:0] b);
    sym_t s;
`ifdef DISPLAY_ARB_CRLF_EN
    if (b == 8'h0A) begin
      s.d = 8'h0D;
      s.last = 1'b0;
      mq.push_back(s);
    end
`endif
    s.d = b;
    s.last = 1'b1;
    mq.push_back(s);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, compare outputs mid-cycle, advance the model.
  task automatic step(input logic lv, input logic [7:0] mb, input logic dv,
                      input logic [7:0] dd, input logic ordy);
    int   n;
    logic acc, popb, cpush, drdy, dpush, has;
    load_val  = lv;
    main_bus  = mb;
    dbg_valid = dv;
    dbg_data  = dd;
    out_ready = ordy;
    @(negedge clk);
    n    = m_bytes();
    has  = (mq.size() > 0);
    drdy = (n < DEPTH) && !lv;
    check("dbg_ready", 8'(dbg_ready), 8'(drdy));
    check("out_valid", 8'(out_valid), 8'(has));
    if (has) check("out_data", out_data, mq[0].d);
    check("fifo_count", 8'(fifo_count), 8'(n));
    check("overflow", 8'(overflow), 8'(m_ovf));
    acc  = ordy && has;
    popb = 1'b0;
    if (acc) popb = mq[0].last;
    cpush = lv && ((n < DEPTH) || popb);
    dpush = dv && drdy;
    if (lv && !cpush) m_ovf = 1'b1;
    if (acc) void'(mq.pop_front());
    if (cpush) m_push(mb);
    else if (dpush) m_push(dd);
    @(posedge clk);
    #1;
  endtask

  // Assert reset between edges and check that its effect is immediate.
  task automatic async_reset();
    load_val  = 1'b0;
    dbg_valid = 1'b0;
    out_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("rst_out_valid", 8'(out_valid), 8'd0);
    check("rst_fifo_count", 8'(fifo_count), 8'd0);
    check("rst_overflow", 8'(overflow), 8'd0);
    check("rst_dbg_ready_idle", 8'(dbg_ready), 8'd1);
    load_val = 1'b1;
    #1;
    check("rst_dbg_ready_cpu", 8'(dbg_ready), 8'd0);
    load_val = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    @(posedge clk);
    #1;
    async_reset();

    // Two CPU bytes streamed straight through
    step(1'b1, 8'h41, 1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h42, 1'b0, 8'h00, 1'b1);
    drain(3);

    // CPU and debug collide: CPU wins, debug lands a cycle later
    step(1'b1, 8'h31, 1'b1, 8'h32, 1'b1);
    step(1'b0, 8'h00, 1'b1, 8'h32, 1'b1);
    drain(3);

    // Nine CPU bytes into a stalled sink: ninth dropped, overflow latched
    for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1, 8'h55, 1'b0);
    drain(10);

    // Full buffer with simultaneous pop and CPU write: byte kept, no overflow
    async_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h7F, 1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    drain(10);

    // Line feed followed by a plain character
    step(1'b1, 8'h0A, 1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h58, 1'b0, 8'h00, 1'b1);
    drain(5);

    // Line feed stalled mid-pair, then debug traffic
    step(1'b1, 8'h0A, 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1, 8'h44, 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    drain(5);

    // Reset while a line feed is half emitted with three bytes buffered
    step(1'b1, 8'h0A, 1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h01, 1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h02, 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    async_reset();
    drain(4);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic       lv, dv, ordy;
      logic [7:0] mb, dd;
      lv   = ($urandom_range(0, 3) == 0);
      dv   = ($urandom_range(0, 1) == 0);
      ordy = ($urandom_range(0, 2) != 0);
      mb   = ($urandom_range(0, 4) == 0) ? 8'h0A : 8'($urandom);
      dd   = ($urandom_range(0, 4) == 0) ? 8'h0A : 8'($urandom);
      if (i >= 150 && i < 190) ordy = 1'b0;
      step(lv, mb, dv, dd, ordy);
    end
    drain(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
